// File: rtl/alu_result_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ser_pkg
// Purpose  : Shared types and constants for the ALU result serializer.
//            Frame FSM state encoding, output byte width, status byte layout
//            and the byte-counter width helper.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package alu_ser_pkg;

  // Output byte width; the transmit path is byte-oriented.
  localparam int BYTE_WIDTH = 8;

  // Position of the latched ALU carry inside the trailing status byte.
  localparam int STATUS_CARRY_BIT = 0;

  // Frame FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_DATA   = 2'd1,
    SEND_STATUS = 2'd2
  } ser_state_e;

  // Width of the byte counter for a result of nbytes bytes: clog2(nbytes),
  // never narrower than one bit so a single-byte result still has a counter.
  function automatic int cnt_width(input int nbytes);
    if (nbytes <= 1) begin
      return 1;
    end
    return $clog2(nbytes);
  endfunction

endpackage : alu_ser_pkg
`default_nettype wire

// File: rtl/alu_result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_serializer_if
// Purpose  : Bundles the ALU-side capture inputs and the byte-stream
//            valid/ready transmit signals of the serializer.
// Ports    : alu_out    - ALU result bits
//            carry_in   - ALU carry, sampled with alu_out
//            out_valid  - ALU output-valid level
//            tx_data    - current frame byte
//            tx_valid   - tx_data holds a byte to transfer
//            tx_ready   - consumer accepts the byte this cycle
//            busy       - frame in progress
//            frame_done - one-cycle pulse after the status byte is accepted
//            overrun    - one-cycle pulse when a result is dropped
//            modport slave  : serializer view
//            modport master : environment (ALU + transmitter) view
// Revision : 1.0 - initial release
// ============================================================================
interface alu_result_serializer_if #(
  parameter int OUT_WIDTH = 32
);
  import alu_ser_pkg::*;

  logic [OUT_WIDTH-1:0]  alu_out;
  logic                  carry_in;
  logic                  out_valid;
  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  modport slave (
    input  alu_out, carry_in, out_valid, tx_ready,
    output tx_data, tx_valid, busy, frame_done, overrun
  );

  modport master (
    output alu_out, carry_in, out_valid, tx_ready,
    input  tx_data, tx_valid, busy, frame_done, overrun
  );

endinterface : alu_result_serializer_if
`default_nettype wire

// File: rtl/alu_result_serializer_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Purpose  : Registers a level signal and flags its rising edge. The pulse
//            is high in the cycle where the level is 1 and was 0 one cycle
//            earlier, so a level held high yields exactly one pulse.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - synchronous active-low reset
//            level_i - level input (ALU output-valid)
//            rise_o  - one-cycle rising-edge pulse
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic level_i,
  output logic      rise_o
);

  logic valid_q;

  // Cleared by reset, so a level already high right after reset is seen
  // as a rising edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= level_i;
    end
  end

  assign rise_o = level_i & ~valid_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/alu_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_serializer
// Purpose  : Captures a registered ALU result plus carry on the rising edge
//            of the ALU valid flag and streams it as a byte frame over a
//            valid/ready link: result bytes LSB-first, then one status byte
//            {7'b0, carry}. Captures arriving while a frame is in progress
//            are dropped and reported with a one-cycle overrun pulse.
// Ports    : clk_i  - clock, rising edge
//            rst_ni - synchronous active-low reset
//            bus    - alu_result_serializer_if.slave (capture + TX stream)
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int OUT_WIDTH = 32  // multiple of 8
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  alu_result_serializer_if.slave bus
);

  localparam int NBYTES = OUT_WIDTH / BYTE_WIDTH;
  localparam int CNT_W  = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  ser_state_e           state_q, state_d;
  logic [OUT_WIDTH-1:0] shift_q, shift_d;
  logic                 carry_q, carry_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;

  logic capture;
  logic tx_valid;
  logic handshake;

  rise_detect u_rise_detect (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .level_i(bus.out_valid),
    .rise_o (capture)
  );

  // Valid is a pure function of the registered state, so it can never drop
  // mid-frame and never changes while the consumer stalls.
  assign tx_valid  = (state_q != IDLE);
  assign handshake = tx_valid & bus.tx_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    // Any capture outside IDLE (including the final status handshake cycle)
    // is dropped; the running frame is left untouched.
    overrun_d    = capture & (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          shift_d = bus.alu_out;
          carry_d = bus.carry_in;
          cnt_d   = '0;
          state_d = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (handshake) begin
          shift_d = shift_q >> BYTE_WIDTH;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BYTE) begin
            state_d = SEND_STATUS;
          end
        end
      end
      SEND_STATUS: begin
        if (handshake) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (decoded from registers only)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.tx_data    = '0;
    bus.tx_valid   = tx_valid;
    bus.busy       = tx_valid;
    bus.frame_done = frame_done_q;
    bus.overrun    = overrun_q;
    unique case (state_q)
      SEND_DATA:   bus.tx_data = shift_q[BYTE_WIDTH-1:0];
      SEND_STATUS: bus.tx_data[STATUS_CARRY_BIT] = carry_q;
      default:     bus.tx_data = '0;
    endcase
  end

endmodule : alu_result_serializer
`default_nettype wire

// File: tb/tb_alu_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_serializer
// Purpose  : Directed self-checking bench for alu_result_serializer with
//            OUT_WIDTH=32 (frames of four result bytes plus a status byte).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_serializer;

  localparam int OUT_WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_result_serializer_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

  alu_result_serializer #(.OUT_WIDTH(OUT_WIDTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled and inputs driven 1 ns
  // after the rising edge, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.out_valid = 1'b0;
    bus.alu_out   = '0;
    bus.carry_in  = 1'b0;
    bus.tx_ready  = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle tx_valid got %b want 0", bus.tx_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic_frame();
    logic [7:0] exp [5];
    exp[0] = 8'h78; exp[1] = 8'h56; exp[2] = 8'h34; exp[3] = 8'h12; exp[4] = 8'h01;
    bus.alu_out = 32'h1234_5678; bus.carry_in = 1'b1; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_before got %b want 0", bus.busy); end
    step();
    bus.out_valid = 1'b0; bus.alu_out = 32'hCAFE_F00D; bus.carry_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i] || bus.busy !== 1'b1)
        begin n_fail++; $display("FAIL basic_byte%0d got v=%b d=%h b=%b want v=1 d=%h b=1", i, bus.tx_valid, bus.tx_data, bus.busy, exp[i]); end
      step();
    end
    n_checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.tx_valid !== 1'b0)
      begin n_fail++; $display("FAIL basic_done got fd=%b b=%b v=%b want fd=1 b=0 v=0", bus.frame_done, bus.busy, bus.tx_valid); end
    step();
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.frame_done); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [7:0] exp [5];
    exp[0] = 8'h78; exp[1] = 8'h56; exp[2] = 8'h34; exp[3] = 8'h12; exp[4] = 8'h01;
    bus.alu_out = 32'h1234_5678; bus.carry_in = 1'b1; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    step();
    bus.out_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h56)
            begin n_fail++; $display("FAIL stall%0d got v=%b d=%h want v=1 d=56", s, bus.tx_valid, bus.tx_data); end
          step();
        end
        bus.tx_ready = 1'b1;
      end
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i])
        begin n_fail++; $display("FAIL bp_byte%0d got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp[i]); end
      step();
    end
    n_checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL bp_done got fd=%b b=%b want fd=1 b=0", bus.frame_done, bus.busy); end
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_level_valid();
    logic [7:0] exp [5];
    int         ovr_seen;
    int         frames;
    exp[0] = 8'h0A; exp[1] = 8'h00; exp[2] = 8'h00; exp[3] = 8'h00; exp[4] = 8'h00;
    ovr_seen = 0;
    frames   = 0;
    bus.carry_in = 1'b0; bus.tx_ready = 1'b1; bus.out_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.alu_out = 32'h0000_000A + 32'(c);
      bus.out_valid = (c < 10);
      if (c >= 1 && c <= 5) begin
        n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[c-1])
          begin n_fail++; $display("FAIL level_byte%0d got v=%b d=%h want v=1 d=%h", c - 1, bus.tx_valid, bus.tx_data, exp[c-1]); end
      end
      if (bus.overrun === 1'b1) ovr_seen++;
      if (bus.frame_done === 1'b1) frames++;
      if (c > 6 && bus.tx_valid !== 1'b0) frames += 10;
      step();
    end
    n_checks++; if (frames !== 1) begin n_fail++; $display("FAIL level_frames got %0d want 1", frames); end
    n_checks++; if (ovr_seen !== 0) begin n_fail++; $display("FAIL level_overrun got %0d want 0", ovr_seen); end
    idle_inputs();
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_overrun();
    logic [7:0] exp [5];
    int         ovr_cnt;
    int         ef_seen;
    exp[0] = 8'h78; exp[1] = 8'h56; exp[2] = 8'h34; exp[3] = 8'h12; exp[4] = 8'h01;
    ovr_cnt = 0;
    ef_seen = 0;
    bus.alu_out = 32'h1234_5678; bus.carry_in = 1'b1; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.out_valid = (i == 1);
      if (i == 1) begin bus.alu_out = 32'hDEAD_BEEF; bus.carry_in = 1'b0; end
      if (i == 2) begin
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse got %b want 1", bus.overrun); end
      end
      if (bus.overrun === 1'b1) ovr_cnt++;
      if (bus.tx_data === 8'hEF) ef_seen++;
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i])
        begin n_fail++; $display("FAIL ovr_byte%0d got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp[i]); end
      step();
    end
    n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL ovr_done got %b want 1", bus.frame_done); end
    for (int c = 0; c < 3; c++) begin
      if (bus.overrun === 1'b1) ovr_cnt++;
      if (bus.tx_valid === 1'b1 || bus.tx_data === 8'hEF) ef_seen++;
      step();
    end
    n_checks++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_count got %0d want 1", ovr_cnt); end
    n_checks++; if (ef_seen !== 0) begin n_fail++; $display("FAIL ovr_dropped_emitted got %0d want 0", ef_seen); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_negative();
    logic [7:0] exp [5];
    exp[0] = 8'hF6; exp[1] = 8'hFF; exp[2] = 8'hFF; exp[3] = 8'hFF; exp[4] = 8'h00;
    bus.alu_out = 32'hFFFF_FFF6; bus.carry_in = 1'b0; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    step();
    bus.out_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i])
        begin n_fail++; $display("FAIL neg_byte%0d got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp[i]); end
      step();
    end
    n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL neg_done got %b want 1", bus.frame_done); end
    step();
  endtask

  // --------------------------------------------------------------------------
  // Rise during the final status handshake: dropped, overrun and frame_done
  // land in the same cycle.
  task automatic test_overrun_at_status();
    bus.alu_out = 32'h0102_0304; bus.carry_in = 1'b0; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    step();
    bus.out_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b1)
      begin n_fail++; $display("FAIL stat_ovr_status got v=%b d=%h want v=1 d=00", bus.tx_valid, bus.tx_data); end
    bus.out_valid = 1'b1; bus.alu_out = 32'h5555_5555; bus.carry_in = 1'b1;
    step();
    n_checks++; if (bus.frame_done !== 1'b1 || bus.overrun !== 1'b1 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL stat_ovr_same_cycle got fd=%b ov=%b b=%b want fd=1 ov=1 b=0", bus.frame_done, bus.overrun, bus.busy); end
    step();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL stat_ovr_dropped got v=%b want 0", bus.tx_valid); end
    idle_inputs();
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midframe();
    logic [7:0] exp [5];
    int         stray;
    exp[0] = 8'h0F; exp[1] = 8'h0F; exp[2] = 8'hA5; exp[3] = 8'hA5; exp[4] = 8'h01;
    stray = 0;
    bus.alu_out = 32'h1234_5678; bus.carry_in = 1'b1; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    step();
    bus.out_valid = 1'b0;
    step();
    n_checks++; if (bus.tx_data !== 8'h56) begin n_fail++; $display("FAIL rst_mid_byte1 got %h want 56", bus.tx_data); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.overrun !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_outputs got d=%h v=%b b=%b fd=%b ov=%b want all 0", bus.tx_data, bus.tx_valid, bus.busy, bus.frame_done, bus.overrun); end
    for (int c = 0; c < 4; c++) begin
      if (bus.tx_valid !== 1'b0 || bus.frame_done !== 1'b0) stray++;
      step();
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_mid_abandon got %0d stray cycles want 0", stray); end
    bus.alu_out = 32'hA5A5_0F0F; bus.carry_in = 1'b1; bus.out_valid = 1'b1;
    step();
    bus.out_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i])
        begin n_fail++; $display("FAIL rst_new_byte%0d got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, exp[i]); end
      step();
    end
    n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL rst_new_done got %b want 1", bus.frame_done); end
    step();
  endtask

  // --------------------------------------------------------------------------
  // Valid already high as reset is released counts as a rising edge.
  task automatic test_valid_high_after_reset();
    bus.alu_out = 32'h0000_00C3; bus.carry_in = 1'b1; bus.out_valid = 1'b1; bus.tx_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rvh_in_reset got v=%b want 0", bus.tx_valid); end
    step();
    n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hC3)
      begin n_fail++; $display("FAIL rvh_capture got v=%b d=%h want v=1 d=c3", bus.tx_valid, bus.tx_data); end
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (bus.tx_data !== 8'h01) begin n_fail++; $display("FAIL rvh_status got %h want 01", bus.tx_data); end
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_level_valid();
    test_overrun();
    test_negative();
    test_overrun_at_status();
    test_reset_midframe();
    test_valid_high_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_result_serializer
`default_nettype wire

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the arithmetic unit. It captures each new registered ALU result (`ALU_OUT` plus carry) when the ALU's output-valid flag rises, and streams the result as a byte frame over a valid/ready interface to the UART TX path. The frame is the result bytes LSB-first, followed by one status byte. It decouples the single-cycle ALU result from the byte-at-a-time, back-pressured transmitter.

## Interface
- `OUT_WIDTH`, 32, result width; must be a multiple of 8.
- `BYTE_WIDTH`, 8, output data width; fixed at 8.
- `CLK`  in  1  single clock, all logic on rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `ALU_OUT`  in  OUT_WIDTH  ALU result, raw two's-complement bits.
- `CARRY_IN`  in  1  ALU carry, sampled with `ALU_OUT`.
- `OUT_VALID`  in  1  ALU valid flag; level signal that may stay high for many cycles.
- `TX_DATA`  out  8  current frame byte.
- `TX_VALID`  out  1  `TX_DATA` holds a byte to transfer.
- `TX_READY`  in  1  consumer accepts the byte this cycle.
- `BUSY`  out  1  frame in progress (state != IDLE).
- `FRAME_DONE`  out  1  one-cycle pulse after the status byte is accepted.
- `OVERRUN`  out  1  one-cycle pulse when a result is dropped.

## Operation
- NBYTES = OUT_WIDTH/8. Frame length = NBYTES+1 bytes.
- Frame order: result byte 0 (bits 7:0) first, through byte NBYTES-1, then the status byte {7'b0, carry}. Sign is not interpreted; bits pass through unchanged.
- Capture event: `OUT_VALID`=1 and `valid_d`=0, where `valid_d` is `OUT_VALID` registered one cycle. Exactly one capture per rising edge, regardless of how long `OUT_VALID` stays high.
- States:
  - IDLE: `TX_VALID`=0. On a capture event, load `ALU_OUT` into the shift register, latch the carry, clear the byte counter, go to SEND_DATA.
  - SEND_DATA: `TX_VALID`=1 and `TX_DATA` = shift_reg[7:0]. On handshake (`TX_VALID`&`TX_READY`), shift right 8 and increment the counter. On the handshake of byte NBYTES-1, go to SEND_STATUS.
  - SEND_STATUS: `TX_VALID`=1 and `TX_DATA`={7'b0,carry}. On handshake, go to IDLE and assert `FRAME_DONE` for one cycle.
- Handshake rules: while `TX_VALID`=1 and `TX_READY`=0, `TX_DATA` and `TX_VALID` must not change. `TX_VALID` never drops mid-frame.
- Capture event in any state other than IDLE, including the cycle of the final status handshake: the result is dropped, `OVERRUN` pulses next cycle, and the frame in progress is unaffected.
- Reset:
  - All outputs are 0: `TX_DATA`=0, `TX_VALID`=0, `BUSY`=0, `FRAME_DONE`=0, `OVERRUN`=0.
  - Internal state: state=IDLE, shift register, carry and counter cleared, `valid_d`=0.
  - A frame in progress is abandoned with no further bytes.
  - If `OUT_VALID` is already high in the first cycle after reset, that counts as a rising edge and is captured.

## Timing
- Capture at edge k. `TX_VALID`=1 with byte 0 from cycle k+1 (all outputs registered).
- With `TX_READY` held high, one byte transfers per cycle: byte 0 through the status byte occupy cycles k+1 … k+NBYTES+1.
- `FRAME_DONE` is high in cycle k+NBYTES+2; `BUSY` is 0 in the same cycle.
- Earliest next capture is at the edge ending cycle k+NBYTES+2. Minimum spacing between accepted results is NBYTES+2 cycles (6 for OUT_WIDTH=32).
- `OVERRUN` and `FRAME_DONE` can assert in the same cycle.

## Structure
- Package `alu_ser_pkg`:
  - state enum {IDLE, SEND_DATA, SEND_STATUS}
  - `BYTE_WIDTH`
  - status byte carry bit index (0)
  - function computing the counter width as clog2(NBYTES)
- Sub-module `rise_detect`: registers `OUT_VALID` and outputs the one-cycle capture pulse. It shares the same synchronous active-low reset.
- Everything else lives in one module: the FSM, the shift register and the byte counter.

## Test plan
- `ALU_OUT`=0x12345678, carry=1, `TX_READY`=1 → `TX_DATA` 78,56,34,12,01 on 5 consecutive cycles, `FRAME_DONE` in the 6th cycle, `BUSY` 1→0.
- Same result, `TX_READY`=0 for 3 cycles while byte 0x56 is presented → `TX_DATA`=0x56 and `TX_VALID`=1 held stable for those 3 cycles; frame otherwise identical.
- `OUT_VALID` held high 10 cycles while `ALU_OUT` changes every cycle (first value 0x0000000A) → exactly one frame 0A,00,00,00,carry and no `OVERRUN`.
- `OUT_VALID` pulses at the capture edge and again 2 cycles later with 0xDEADBEEF → `OVERRUN` pulses once, the first frame completes unchanged, and no 0xEF byte is emitted.
- `ALU_OUT`=0xFFFFFFF6 (−10), carry=0 → F6,FF,FF,FF,00.
- `RST`=0 for one cycle right after byte 1 is accepted → next cycle all outputs 0 and `BUSY`=0, no remaining bytes; a fresh `OUT_VALID` rise then produces a complete new frame.
